// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
package fpga_cfg_pkg;

  localparam int unsigned CFG_WORD_W    = 224;
  localparam int unsigned CFG_NUM_WORDS = 245;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StArm,
    StReady,
    StError
  } cfg_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_dec.sv
// Row index to one-hot row strobe, gated by the write strobe.
module cfg_onehot_dec #(
  parameter int unsigned NumWords = 4,
  parameter int unsigned IdxW     = 2
) (
  input  logic [IdxW-1:0]     idx_i,
  input  logic                wr_i,
  output logic [NumWords-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NumWords; i++) begin
      onehot_o[i] = wr_i && (idx_i == IdxW'(i));
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams bitstream words into the fabric row by row, then settles, arms
// the fabric flip-flops and reports ready.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned WORD_W        = CFG_WORD_W,
  parameter int unsigned NUM_WORDS     = CFG_NUM_WORDS,
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned ARM_GAP       = 1
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WORD_W-1:0]              s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic [WORD_W-1:0]              cfg_data,
  output logic [NUM_WORDS-1:0]           cfg_en,
  output logic                           ff_en,
  output logic                           rdy,
  output logic                           busy,
  output logic                           err,
  output logic [$clog2(NUM_WORDS+1)-1:0] words_loaded
);

  localparam int unsigned IdxW   = clog2(NUM_WORDS);
  localparam int unsigned WlW    = $clog2(NUM_WORDS + 1);
  localparam int unsigned CntMax = (SETTLE_CYCLES > ARM_GAP) ? SETTLE_CYCLES : ARM_GAP;
  localparam int unsigned CntW   = clog2(CntMax + 1);

  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_WORDS - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] ArmLast    = CntW'(ARM_GAP - 1);

  cfg_state_e               state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [WlW-1:0]           wl_q, wl_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [WORD_W-1:0]        cfg_data_q, cfg_data_d;
  logic [NUM_WORDS-1:0]     cfg_en_q, row_strobe;
  logic                     accept;

  cfg_onehot_dec #(
    .NumWords (NUM_WORDS),
    .IdxW     (IdxW)
  ) u_dec (
    .idx_i    (idx_q),
    .wr_i     (accept),
    .onehot_o (row_strobe)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wl_d       = wl_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    cfg_data_d = cfg_data_q;
    s_ready    = 1'b0;
    ff_en      = 1'b0;
    rdy        = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      StLoad: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        accept  = s_valid;
        if (accept) begin
          cfg_data_d = s_data;
          idx_d      = idx_q + IdxW'(1);
          wl_d       = wl_q + WlW'(1);
          // The word is written even when its length marker is wrong.
          if (idx_q == LastIdx) begin
            if (s_last) begin
              state_d = StSettle;
              cnt_d   = '0;
            end else begin
              state_d = StError;
              err_d   = 1'b1;
            end
          end else if (s_last) begin
            state_d = StError;
            err_d   = 1'b1;
          end
        end
      end
      StSettle: begin
        busy = 1'b1;
        if (cnt_q == SettleLast) begin
          state_d = StArm;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StArm: begin
        ff_en = 1'b1;
        if (cnt_q == ArmLast) begin
          state_d = StReady;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StReady: begin
        ff_en = 1'b1;
        rdy   = 1'b1;
      end
      StIdle, StError: ;
      default: state_d = StIdle;
    endcase

    // Idle, ready and error sessions can all be (re)started.
    if (start && (state_q == StIdle || state_q == StReady || state_q == StError)) begin
      state_d = StLoad;
      idx_d   = '0;
      wl_d    = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      wl_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      cfg_data_q <= '0;
      cfg_en_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wl_q       <= wl_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      cfg_data_q <= cfg_data_d;
      cfg_en_q   <= row_strobe;
    end
  end

  assign cfg_data     = cfg_data_q;
  assign cfg_en       = cfg_en_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader with four rows, settle 3 and arm gap 1.
module tb_fpga_cfg_loader;

  localparam int unsigned W  = 8;
  localparam int unsigned NW = 4;
  localparam int unsigned SC = 3;
  localparam int unsigned AG = 1;

  logic          clock = 1'b0;
  logic          rst, start, s_valid, s_last;
  logic [W-1:0]  s_data;
  logic          s_ready, ff_en, rdy, busy, err;
  logic [W-1:0]  cfg_data;
  logic [NW-1:0] cfg_en;
  logic [2:0]    words_loaded;

  int checks   = 0;
  int failures = 0;

  fpga_cfg_loader #(
    .WORD_W        (W),
    .NUM_WORDS     (NW),
    .SETTLE_CYCLES (SC),
    .ARM_GAP       (AG)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .cfg_data     (cfg_data),
    .cfg_en       (cfg_en),
    .ff_en        (ff_en),
    .rdy          (rdy),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic count_until_ff(output int n);
    n = 0;
    while (!ff_en && n < 50) begin
      step();
      n++;
    end
    if (!ff_en) n = -1;
  endtask

  task automatic count_until_rdy(output int n);
    n = 0;
    while (!rdy && n < 50) begin
      step();
      n++;
    end
    if (!rdy) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
    checks++; if (cfg_data !== '0) begin failures++; $display("FAIL rst_cfg_data got=%h exp=00", cfg_data); end
    checks++; if (cfg_en !== '0) begin failures++; $display("FAIL rst_cfg_en got=%b exp=0000", cfg_en); end
    checks++; if ({ff_en, rdy, busy, err} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {ff_en, rdy, busy, err}); end
    checks++; if (words_loaded !== 3'd0) begin failures++; $display("FAIL rst_words got=%0d exp=0", words_loaded); end
    step();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL idle_s_ready got=%b exp=0", s_ready); end
  endtask

  task automatic test_nominal();
    logic [NW-1:0] exp_en;
    int n;
    do_start();
    checks++; if ({s_ready, busy} !== 2'b11) begin failures++; $display("FAIL nom_load got=%b exp=11", {s_ready, busy}); end
    for (int i = 0; i < 4; i++) begin
      send(W'(8'h0A + i), (i == 3));
      exp_en = '0;
      exp_en[i] = 1'b1;
      checks++; if (cfg_en !== exp_en) begin failures++; $display("FAIL nom_en%0d got=%b exp=%b", i, cfg_en, exp_en); end
      checks++; if (cfg_data !== W'(8'h0A + i)) begin failures++; $display("FAIL nom_data%0d got=%h exp=%h", i, cfg_data, W'(8'h0A + i)); end
    end
    checks++; if (words_loaded !== 3'd4) begin failures++; $display("FAIL nom_words got=%0d exp=4", words_loaded); end
    checks++; if ({s_ready, busy, ff_en} !== 3'b010) begin failures++; $display("FAIL nom_settle got=%b exp=010", {s_ready, busy, ff_en}); end
    count_until_ff(n);
    checks++; if (n !== 3) begin failures++; $display("FAIL nom_ff_lat got=%0d exp=3", n); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL nom_rdy_early got=%b exp=0", rdy); end
    count_until_rdy(n);
    checks++; if (n !== 1) begin failures++; $display("FAIL nom_rdy_lat got=%0d exp=1", n); end
    checks++; if ({ff_en, rdy, busy, err} !== 4'b1100) begin failures++; $display("FAIL nom_ready got=%b exp=1100", {ff_en, rdy, busy, err}); end
  endtask

  task automatic test_reconfigure();
    int n;
    do_start();
    checks++; if ({ff_en, rdy, s_ready, busy} !== 4'b0011) begin failures++; $display("FAIL rcf_drop got=%b exp=0011", {ff_en, rdy, s_ready, busy}); end
    checks++; if (words_loaded !== 3'd0) begin failures++; $display("FAIL rcf_words got=%0d exp=0", words_loaded); end
    for (int i = 0; i < 4; i++) send(W'(8'h50 + i), (i == 3));
    checks++; if (cfg_en !== 4'b1000 || cfg_data !== 8'h53) begin failures++; $display("FAIL rcf_last got=%b/%h exp=1000/53", cfg_en, cfg_data); end
    count_until_ff(n);
    checks++; if (n !== 3) begin failures++; $display("FAIL rcf_ff_lat got=%0d exp=3", n); end
    count_until_rdy(n);
    checks++; if (n !== 1) begin failures++; $display("FAIL rcf_rdy_lat got=%0d exp=1", n); end
  endtask

  task automatic test_stall();
    logic [NW-1:0] exp_en;
    int n;
    do_start();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 2; g++) begin
          s_data = 8'hFF;
          step();
          checks++; if (cfg_en !== '0) begin failures++; $display("FAIL stl_gap%0d_%0d got=%b exp=0000", i, g, cfg_en); end
          checks++; if (cfg_data !== W'(8'h20 + i - 1)) begin failures++; $display("FAIL stl_hold%0d_%0d got=%h exp=%h", i, g, cfg_data, W'(8'h20 + i - 1)); end
        end
      end
      send(W'(8'h20 + i), (i == 3));
      exp_en = '0;
      exp_en[i] = 1'b1;
      checks++; if (cfg_en !== exp_en) begin failures++; $display("FAIL stl_en%0d got=%b exp=%b", i, cfg_en, exp_en); end
    end
    count_until_ff(n);
    checks++; if (n !== 3) begin failures++; $display("FAIL stl_ff_lat got=%0d exp=3", n); end
    count_until_rdy(n);
    checks++; if (n !== 1) begin failures++; $display("FAIL stl_rdy_lat got=%0d exp=1", n); end
  endtask

  task automatic test_short();
    do_start();
    send(8'h01, 1'b0);
    checks++; if (cfg_en !== 4'b0001) begin failures++; $display("FAIL sht_en0 got=%b exp=0001", cfg_en); end
    send(8'h02, 1'b1);
    checks++; if (cfg_en !== 4'b0010 || cfg_data !== 8'h02) begin failures++; $display("FAIL sht_en1 got=%b/%h exp=0010/02", cfg_en, cfg_data); end
    checks++; if ({err, s_ready} !== 2'b10) begin failures++; $display("FAIL sht_err got=%b exp=10", {err, s_ready}); end
    checks++; if (words_loaded !== 3'd2) begin failures++; $display("FAIL sht_words got=%0d exp=2", words_loaded); end
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) step();
    s_valid = 1'b0;
    checks++; if ({ff_en, rdy, s_ready, err} !== 4'b0001) begin failures++; $display("FAIL sht_hold got=%b exp=0001", {ff_en, rdy, s_ready, err}); end
    checks++; if (cfg_en !== '0 || words_loaded !== 3'd2) begin failures++; $display("FAIL sht_nowrite got=%b/%0d exp=0000/2", cfg_en, words_loaded); end
  endtask

  task automatic test_long();
    int n;
    do_start();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL lng_clr got=%b exp=0", err); end
    send(8'h31, 1'b0);
    send(8'h32, 1'b0);
    start = 1'b1;
    send(8'h33, 1'b0);
    start = 1'b0;
    checks++; if (words_loaded !== 3'd3) begin failures++; $display("FAIL lng_ign_start got=%0d exp=3", words_loaded); end
    send(8'h34, 1'b0);
    checks++; if (cfg_en !== 4'b1000 || cfg_data !== 8'h34) begin failures++; $display("FAIL lng_wr got=%b/%h exp=1000/34", cfg_en, cfg_data); end
    checks++; if ({err, s_ready, busy} !== 3'b100) begin failures++; $display("FAIL lng_err got=%b exp=100", {err, s_ready, busy}); end
    do_start();
    checks++; if ({err, s_ready} !== 2'b01) begin failures++; $display("FAIL lng_restart got=%b exp=01", {err, s_ready}); end
    for (int i = 0; i < 4; i++) send(W'(8'h40 + i), (i == 3));
    count_until_ff(n);
    count_until_rdy(n);
    checks++; if ({rdy, err} !== 2'b10) begin failures++; $display("FAIL lng_recover got=%b exp=10", {rdy, err}); end
  endtask

  task automatic test_reset_midload();
    do_start();
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    s_data  = 8'h63;
    s_valid = 1'b1;
    rst     = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (cfg_en !== '0 || cfg_data !== '0) begin failures++; $display("FAIL rml_out got=%b/%h exp=0000/00", cfg_en, cfg_data); end
    checks++; if ({s_ready, ff_en, rdy, busy, err} !== 5'b0) begin failures++; $display("FAIL rml_flags got=%b exp=00000", {s_ready, ff_en, rdy, busy, err}); end
    checks++; if (words_loaded !== 3'd0) begin failures++; $display("FAIL rml_words got=%0d exp=0", words_loaded); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (cfg_en !== '0) begin failures++; $display("FAIL rml_nopulse%0d got=%b exp=0000", i, cfg_en); end
    end
    s_valid = 1'b0;
    rst     = 1'b1;
    start   = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    step();
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rml_rst_wins got=%b exp=0", s_ready); end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    test_reset();
    test_nominal();
    test_reconfigure();
    test_stall();
    test_short();
    test_long();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpga_cfg_loader.md
Name: fpga_cfg_loader

Overview:
- Synthesizable, parametrised configuration loader for the `fpga` fabric core.
- Accepts a stream of bitstream words over a valid/ready handshake.
- Writes each word into the fabric one configuration row at a time, using a one-hot row strobe.
- After a settle window it enables the fabric flip-flops and raises a ready flag; supports reconfiguration without reset and flags length errors.

Parameters:
- WORD_W, 224, width of one configuration word (fabric configs_in width)
- NUM_WORDS, 245, configuration rows in the fabric (configs_en width)
- SETTLE_CYCLES, 10, idle cycles between last row write and ff_en assertion (>=1)
- ARM_GAP, 1, cycles between ff_en rising and rdy rising (>=1)

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a (re)configuration
- s_data  in  WORD_W  configuration word
- s_valid  in  1  s_data valid
- s_last  in  1  marks final word of the bitstream
- s_ready  out  1  loader accepts a word this cycle
- cfg_data  out  WORD_W  word driven to fabric configs_in
- cfg_en  out  NUM_WORDS  one-hot row write strobe to fabric configs_en
- ff_en  out  1  fabric flip-flop enable
- rdy  out  1  fabric configured and running
- busy  out  1  loader in LOAD or SETTLE
- err  out  1  sticky length-mismatch flag
- words_loaded  out  $clog2(NUM_WORDS+1)  count of rows written this session

Behaviour:
- Reset values: s_ready=0, cfg_data=0, cfg_en=0, ff_en=0, rdy=0, busy=0, err=0, words_loaded=0, state=IDLE. Reset mid-load abandons the session immediately; no further cfg_en pulses.
- States: IDLE, LOAD, SETTLE, ARM, READY, ERROR.
- IDLE: s_ready=0. start -> LOAD, clear idx, words_loaded and err.
- LOAD: s_ready=1, busy=1, ff_en=0, rdy=0.
  - A word is accepted when s_valid && s_ready in cycle N.
  - Cycle N+1: cfg_data=s_data and cfg_en=(1<<idx) for exactly one cycle. idx and words_loaded increment.
  - cfg_en is 0 on every cycle without a write. cfg_data holds its last value.
- Word acceptance with idx==NUM_WORDS-1:
  - If s_last=1: -> SETTLE.
  - If s_last=0: err=1 -> ERROR. The word is still written.
- s_last=1 on an accepted word with idx<NUM_WORDS-1: word written, err=1 -> ERROR.
- SETTLE: s_ready=0, busy=1. Counter runs SETTLE_CYCLES cycles after the final cfg_en pulse, then -> ARM.
- ARM: ff_en=1 from the first ARM cycle. After ARM_GAP cycles -> READY.
- READY: ff_en=1, rdy=1, busy=0. start -> LOAD with ff_en and rdy dropped the next cycle; the fabric is frozen during reload.
- ERROR: ff_en=0, rdy=0, s_ready=0, err held. Only start or rst leaves; start clears err and enters LOAD.
- start in LOAD, SETTLE or ARM is ignored.
- start coincident with rst: rst wins.
- s_valid while s_ready=0 is not consumed; the source holds the data.
- Latency: start to first s_ready is 1 cycle. With no stalls, last word accepted to ff_en is SETTLE_CYCLES+1 cycles, and to rdy is SETTLE_CYCLES+1+ARM_GAP cycles.
- Throughput: one word per cycle in LOAD; back-pressure comes only from state, never mid-load.

Decomposition:
- Package fpga_cfg_pkg holds:
  - the state enum (6 states, 3-bit);
  - the idx width function clog2;
  - default constants CFG_WORD_W=224, CFG_NUM_WORDS=245.
- Sub-module cfg_onehot_dec (idx -> NUM_WORDS one-hot, gated by write strobe) is natural and is instantiated once.
- Everything else (FSM, counters, output registers) stays in fpga_cfg_loader.

Test Plan:
- Nominal, NUM_WORDS=4, SETTLE_CYCLES=3, ARM_GAP=1:
  - Stimulus: start, then 4 back-to-back words 0xA,0xB,0xC,0xD with last on word 4.
  - Response: cfg_en pulses 0001,0010,0100,1000 on consecutive cycles with matching cfg_data; ff_en rises 4 cycles after the 4th acceptance; rdy rises 1 cycle after ff_en; words_loaded=4.
- Stalled source: s_valid toggles 1,0,0,1,... -> cfg_en pulses only the cycle after each acceptance, zeros between; final timing measured from the last acceptance is unchanged.
- Short bitstream: s_last on word 2 of 4 -> rows 0001,0010 written; err=1; ff_en and rdy stay 0; s_ready=0 afterwards; words_loaded=2.
- Long bitstream: 4th word without s_last -> err=1, ERROR state. A new start clears err and a correct 4-word load reaches rdy=1.
- Reconfigure: from READY, pulse start -> ff_en and rdy drop next cycle; reload of 4 words -> rdy re-asserts with the same latency.
- Reset mid-load: assert rst after 2 words -> all outputs return to reset values the next cycle; s_valid held high produces no cfg_en pulse.
